// File: rtl/count_seq_checker_if.sv
// Bus between a sequence source (or bench) and the count sequence checker.
// The master drives samples and clear; the slave returns lock/error status.
interface count_seq_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             en;
    logic [WIDTH-1:0] count_in;
    logic             clr;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [ERR_W-1:0] wrap_count;
    logic [WIDTH-1:0] expected;

    modport master (
        output en, count_in, clr,
        input  locked, err_pulse, err_count, wrap_count, expected
    );

    modport slave (
        input  en, count_in, clr,
        output locked, err_pulse, err_count, wrap_count, expected
    );
endinterface

// File: rtl/count_seq_checker.sv
// Receive-side monitor for a free-running counter: checks each strobed sample
// is the previous one plus one (mod 2^WIDTH), tracking lock, errors and wraps.
//
// state  | meaning
// IDLE   | no sample taken yet since reset
// ACQ    | counting consecutive good increments toward lock
// LOCKED | sequence trusted; breaks are counted as errors
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input logic                clk,
    input logic                reset,
    count_seq_checker_if.slave bus
);
    localparam int RUN_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [RUN_W-1:0] run;
    logic             locked_q;
    logic             err_pulse_q;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] wrap_q;
    logic [WIDTH-1:0] expected_q;

    logic [WIDTH-1:0] prev_inc;
    logic             good;
    logic             err_inc;
    logic             wrap_inc;
    logic             run_done;

    always_comb begin
        prev_inc = prev + WIDTH'(1);
        good     = (bus.count_in == prev_inc);
        run_done = ((run + RUN_W'(1)) == RUN_W'(LOCK_CNT));
        err_inc  = bus.en && (state == LOCKED) && !good;
        // A good step landing on zero can only come from all-ones
        wrap_inc = bus.en && (state == LOCKED) && good && (prev == '1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            prev        <= '0;
            run         <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_q       <= '0;
            wrap_q      <= '0;
            expected_q  <= '0;
        end else begin
            err_pulse_q <= 1'b0;

            if (bus.en) begin
                // prev tracks the raw sample even on a break so we resync from it
                prev       <= bus.count_in;
                expected_q <= bus.count_in + WIDTH'(1);

                unique case (state)
                    IDLE: begin
                        run   <= '0;
                        state <= ACQ;
                    end
                    ACQ: begin
                        if (good) begin
                            if (run_done) begin
                                state    <= LOCKED;
                                locked_q <= 1'b1;
                                run      <= '0;
                            end else begin
                                run <= run + RUN_W'(1);
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!good) begin
                            err_pulse_q <= 1'b1;
                            locked_q    <= 1'b0;
                            run         <= '0;
                            state       <= ACQ;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        locked_q <= 1'b0;
                        run      <= '0;
                    end
                endcase
            end

            if (bus.clr) begin
                err_q  <= '0;
                wrap_q <= '0;
            end else begin
                if (err_inc && (err_q != '1)) begin
                    err_q <= err_q + ERR_W'(1);
                end
                if (wrap_inc && (wrap_q != '1)) begin
                    wrap_q <= wrap_q + ERR_W'(1);
                end
            end
        end
    end

    assign bus.locked     = locked_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_count  = err_q;
    assign bus.wrap_count = wrap_q;
    assign bus.expected   = expected_q;
endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: directed scenarios followed by
// randomized traffic, compared cycle by cycle against a behavioural model.
module tb_count_seq_checker;
    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 3;
    localparam int ERR_W    = 2;
    localparam int MODV     = 1 << WIDTH;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    count_seq_checker_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

    count_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int locked;
        int pulse;
        int err;
        int wrap;
        int expv;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // behavioural model state
    bit m_started;
    int m_prev;
    int m_streak;
    bit m_locked;
    int m_err;
    int m_wrap;
    int m_pulse;
    int m_exp;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    endtask

    function automatic void model_reset();
        m_started = 0;
        m_prev    = 0;
        m_streak  = 0;
        m_locked  = 0;
        m_err     = 0;
        m_wrap    = 0;
        m_pulse   = 0;
        m_exp     = 0;
    endfunction

    function automatic void model_sample(input bit e, input int c, input bit cl);
        bit good;
        m_pulse = 0;
        if (e) begin
            good = (((m_prev + 1) % MODV) == c);
            if (!m_started) begin
                m_started = 1;
                m_streak  = 0;
            end else if (m_locked) begin
                if (good) begin
                    if (c == 0 && m_wrap < ERR_MAX) m_wrap++;
                end else begin
                    m_pulse  = 1;
                    m_locked = 0;
                    m_streak = 0;
                    if (m_err < ERR_MAX) m_err++;
                end
            end else if (good) begin
                m_streak++;
                if (m_streak == LOCK_CNT) begin
                    m_locked = 1;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
            m_prev = c;
            m_exp  = (c + 1) % MODV;
        end
        if (cl) begin
            m_err  = 0;
            m_wrap = 0;
        end
    endfunction

    task automatic step(input bit rst_v, input bit e, input int c, input bit cl);
        exp_t x;
        @(negedge clk);
        reset        = rst_v;
        bus.en       = e;
        bus.count_in = c[WIDTH-1:0];
        bus.clr      = cl;
        if (!rst_v) model_reset();
        else model_sample(e, c % MODV, cl);
        x = '{m_locked, m_pulse, m_err, m_wrap, m_exp};
        sb_q.push_back(x);
        @(posedge clk);
    endtask

    task automatic feed(input int c);
        step(1'b1, 1'b1, c, 1'b0);
    endtask

    task automatic feed_good(input int n);
        for (int i = 0; i < n; i++) feed((m_prev + 1) % MODV);
    endtask

    // monitor: pops one expectation per edge that had stimulus behind it
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check("sb_locked", int'(bus.locked), x.locked);
                check("sb_err_pulse", int'(bus.err_pulse), x.pulse);
                check("sb_err_count", int'(bus.err_count), x.err);
                check("sb_wrap_count", int'(bus.wrap_count), x.wrap);
                check("sb_expected", int'(bus.expected), x.expv);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int guard;
        bus.en       = 1'b0;
        bus.count_in = '0;
        bus.clr      = 1'b0;
        model_reset();

        // held in reset with live strobes
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, int'($urandom_range(0, MODV - 1)), 1'b0);

        // lock acquire
        feed(0); feed(1); feed(2);
        #1 check("pre_lock_locked", int'(bus.locked), 0);
        feed(3);
        #1 check("lock_acq_locked", int'(bus.locked), 1);
        check("lock_acq_expected", int'(bus.expected), 4);

        // wrap through all-ones
        for (int c = 4; c <= 15; c++) feed(c);
        feed(0); feed(1);
        #1 check("wrap_count", int'(bus.wrap_count), 1);
        check("wrap_locked", int'(bus.locked), 1);

        // error and relock
        feed(2); feed(3); feed(4); feed(5);
        feed(7);
        #1 check("err_pulse_hi", int'(bus.err_pulse), 1);
        check("err_count_1", int'(bus.err_count), 1);
        check("err_unlocked", int'(bus.locked), 0);
        feed(8);
        #1 check("err_pulse_lo", int'(bus.err_pulse), 0);
        feed(9); feed(10);
        #1 check("relock", int'(bus.locked), 1);
        check("relock_err_count", int'(bus.err_count), 1);

        // gap in strobes
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, int'($urandom_range(0, MODV - 1)), 1'b0);
        #1 check("gap_locked", int'(bus.locked), 1);
        check("gap_expected", int'(bus.expected), 11);

        // saturation: four more errors, relocking between each
        for (int k = 0; k < 4; k++) begin
            feed((m_prev + 2) % MODV);
            feed_good(LOCK_CNT);
        end
        #1 check("err_saturated", int'(bus.err_count), ERR_MAX);
        check("sat_locked", int'(bus.locked), 1);

        // clear wins over a same-cycle error
        step(1'b1, 1'b1, (m_prev + 2) % MODV, 1'b1);
        #1 check("clr_err_count", int'(bus.err_count), 0);
        check("clr_keeps_pulse", int'(bus.err_pulse), 1);

        // relock, wrap once, take one error, relock, then async reset
        feed_good(LOCK_CNT);
        guard = 0;
        while (m_prev != 1 && guard < 2 * MODV) begin
            feed_good(1);
            guard++;
        end
        feed((m_prev + 3) % MODV);
        feed_good(LOCK_CNT);
        #1 check("pre_rst_locked", int'(bus.locked), 1);
        check("pre_rst_wrap", int'(bus.wrap_count), 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("async_locked", int'(bus.locked), 0);
        check("async_err_count", int'(bus.err_count), 0);
        check("async_wrap_count", int'(bus.wrap_count), 0);
        check("async_expected", int'(bus.expected), 0);
        step(1'b0, 1'b1, 5, 1'b0);
        feed(0); feed(1); feed(2); feed(3);
        #1 check("post_rst_relock", int'(bus.locked), 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit rv;
            bit e;
            bit cl;
            int c;
            rv = ($urandom_range(0, 199) != 0);
            e  = ($urandom_range(0, 99) < 75);
            cl = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) == 0) c = int'($urandom_range(0, MODV - 1));
            else c = (m_prev + 1) % MODV;
            step(rv, e, c, cl);
        end

        #2 check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
